alu_io_bridge: RTL

//  Registered bridge between the PIPE_CPU IO register ports and NUM_CH SHARE_SUPERALU-style

---
 rtl/alu_io_bridge.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_io_bridge.sv
// alu_io_bridge: registered bridge between the CPU IO registers and NUM_CH ALU channels.
// Firmware starts an operation with a rising edge on START. The bridge pulses alu_start on
// the selected channel, waits for that channel's done flag or a timeout, and then captures
// FOUT/POUT. Firmware polls io_status and reads the captured results back.
module alu_io_bridge #(
    parameter int GENERAL_REG_WIDTH = 16,
    parameter int DATA_WIDTH        = 13,
    parameter int NUM_CH            = 2,
    parameter int CH_SEL_W          = 2,
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int TO_W              = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [GENERAL_REG_WIDTH-1:0] io_control,
    input  logic [GENERAL_REG_WIDTH-1:0] io_dataoutA,
    input  logic [GENERAL_REG_WIDTH-1:0] io_dataoutB,
    output logic [GENERAL_REG_WIDTH-1:0] io_status,
    output logic [GENERAL_REG_WIDTH-1:0] io_datainA,
    output logic [GENERAL_REG_WIDTH-1:0] io_datainB,
    output logic [NUM_CH*DATA_WIDTH-1:0] alu_x,
    output logic [NUM_CH*DATA_WIDTH-1:0] alu_y,
    output logic [NUM_CH*4-1:0]          alu_type,
    output logic [NUM_CH*2-1:0]          mode_type,
    output logic [NUM_CH-1:0]            alu_start,
    input  logic [NUM_CH*DATA_WIDTH-1:0] alu_fout,
    input  logic [NUM_CH*DATA_WIDTH-1:0] alu_pout,
    input  logic [NUM_CH-1:0]            alu_is_done
);

    // Width of the CH field in io_status, which has room for two bits.
    localparam int CHF_W = (CH_SEL_W < 2) ? CH_SEL_W : 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                state, state_nxt;
    logic                  start_q;
    logic [DATA_WIDTH-1:0] x_q, y_q, res_a, res_b;
    logic [3:0]            type_q;
    logic [1:0]            mode_q;
    logic [CH_SEL_W-1:0]   ch_q;
    logic [TO_W-1:0]       cnt;
    logic                  st_done, st_busy, st_to, st_err;

    // Decoded io_control fields.
    logic                  start_in, launch, type_ok, ch_ok, to_hit;
    logic [CH_SEL_W-1:0]   ch_sel;
    logic [3:0]            type_in;
    logic                  sel_done;
    logic [DATA_WIDTH-1:0] sel_fout, sel_pout;

    assign start_in = io_control[0];
    assign type_in  = io_control[6:3];
    assign ch_sel   = io_control[7 +: CH_SEL_W];
    assign launch   = start_in & ~start_q;
    assign type_ok  = (type_in != 4'd0) && ((type_in & (type_in - 4'd1)) == 4'd0);
    assign ch_ok    = int'(ch_sel) < NUM_CH;
    assign to_hit   = int'(cnt) == TIMEOUT_CYCLES - 1;

    // Operands and op codes are broadcast to every channel; only alu_start is per channel.
    assign alu_x     = {NUM_CH{x_q}};
    assign alu_y     = {NUM_CH{y_q}};
    assign alu_type  = {NUM_CH{type_q}};
    assign mode_type = {NUM_CH{mode_q}};

    // Upper register bits carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{io_dataoutA[GENERAL_REG_WIDTH-1:DATA_WIDTH],
                           io_dataoutB[GENERAL_REG_WIDTH-1:DATA_WIDTH],
                           io_control[GENERAL_REG_WIDTH-1:7+CH_SEL_W]};

    // Select the latched channel's done/result buses and drive its start pulse in ISSUE.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one
        // unassigned and infers a latch.
        sel_done  = 1'b0;
        sel_fout  = '0;
        sel_pout  = '0;
        alu_start = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_q) == i) begin
                sel_done     = alu_is_done[i];
                sel_fout     = alu_fout[i*DATA_WIDTH +: DATA_WIDTH];
                sel_pout     = alu_pout[i*DATA_WIDTH +: DATA_WIDTH];
                alu_start[i] = (state == S_ISSUE);
            end
        end
    end

    // Pack status and zero-extend results onto the CPU-facing registers.
    always_comb begin
        io_status                = '0;
        io_status[3:0]           = {st_err, st_to, st_busy, st_done};
        io_status[4 +: CHF_W]    = ch_q[CHF_W-1:0];
        io_datainA               = '0;
        io_datainA[DATA_WIDTH-1:0] = res_a;
        io_datainB               = '0;
        io_datainB[DATA_WIDTH-1:0] = res_b;
    end

    // Next-state decision for the launch / issue / wait / done sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch) state_nxt = (type_ok && ch_ok) ? S_ISSUE : S_DONE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (sel_done || to_hit) state_nxt = S_DONE;
            S_DONE:  if (!start_in) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Operand latches, timeout counter, status flags and captured results.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            type_q  <= '0;
            mode_q  <= '0;
            ch_q    <= '0;
            cnt     <= '0;
            res_a   <= '0;
            res_b   <= '0;
            st_done <= 1'b0;
            st_busy <= 1'b0;
            st_to   <= 1'b0;
            st_err  <= 1'b0;
        end else begin
            start_q <= start_in;
            case (state)
                S_IDLE: if (launch) begin
                    x_q    <= io_dataoutA[DATA_WIDTH-1:0];
                    y_q    <= io_dataoutB[DATA_WIDTH-1:0];
                    type_q <= type_in;
                    mode_q <= io_control[2:1];
                    // An out-of-range channel is never stored, so the CH field stays valid.
                    ch_q   <= ch_ok ? ch_sel : '0;
                    if (type_ok && ch_ok) begin
                        st_busy <= 1'b1;
                    end else begin
                        st_done <= 1'b1;
                        st_err  <= 1'b1;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (sel_done) begin
                        res_a   <= sel_fout;
                        res_b   <= sel_pout;
                        st_done <= 1'b1;
                        st_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                        if (to_hit) begin
                            st_to   <= 1'b1;
                            st_done <= 1'b1;
                            st_busy <= 1'b0;
                        end
                    end
                end
                S_DONE: if (!start_in) begin
                    st_done <= 1'b0;
                    st_to   <= 1'b0;
                    st_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
